// File: rtl/matrix_operand_sequencer.sv
// Streams the 16 row-major (M[r][c], P[c]) operand pairs of a stored 4x4 matrix and 4-vector
// into a two-cycle-cadence multiplier. Optional feature macro: SEQ_WAIT_MULT_DONE_EN.
//
// state | meaning
// IDLE  | waiting for start; operand writes accepted
// SETUP | operands for pair k presented next cycle, strobe low
// ISSUE | strobe high for pair k; advance k or finish
// WAIT  | (SEQ_WAIT_MULT_DONE_EN only) hold off seq_done until mult_done
// DONE  | one-cycle completion; operand writes accepted
module matrix_operand_sequencer #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              mult_done,
  output logic [OUT_W-1:0]  in1,
  output logic [OUT_W-1:0]  in2,
  output logic              inputs_to_multiply_ready,
  output logic              busy,
  output logic              seq_done
);

`ifdef SEQ_WAIT_MULT_DONE_EN
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_DONE} state_t;
  logic unused_mult_done;
  assign unused_mult_done = mult_done;
`endif

  state_t      state, state_nxt;
  logic [3:0]  k, k_nxt;
  logic [DATA_W-1:0] mat [16];
  logic [DATA_W-1:0] pix [4];
  logic        wr_ok;

  assign wr_ok = (state == S_IDLE) || (state == S_DONE);

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SETUP;
          k_nxt     = 4'd0;
        end
      end
      S_SETUP: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (k != 4'd15) begin
          k_nxt     = k + 4'd1;
          state_nxt = S_SETUP;
        end else begin
`ifdef SEQ_WAIT_MULT_DONE_EN
          state_nxt = S_WAIT;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef SEQ_WAIT_MULT_DONE_EN
      S_WAIT: begin
        if (mult_done) state_nxt = S_DONE;
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      k     <= 4'd0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Outputs are registered from the current state, so they lag it by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      in1                      <= '0;
      in2                      <= '0;
      inputs_to_multiply_ready <= 1'b0;
      busy                     <= 1'b0;
      seq_done                 <= 1'b0;
    end else begin
      inputs_to_multiply_ready <= (state == S_ISSUE);
`ifdef SEQ_WAIT_MULT_DONE_EN
      busy <= (state == S_SETUP) || (state == S_ISSUE) || (state == S_WAIT);
`else
      busy <= (state == S_SETUP) || (state == S_ISSUE);
`endif
      seq_done <= (state == S_DONE);
      if (state == S_SETUP) begin
        in1 <= {{(OUT_W-DATA_W){1'b0}}, mat[k]};
        in2 <= {{(OUT_W-DATA_W){1'b0}}, pix[k[1:0]]};
      end
    end
  end

  // Matrix address layout (addr = r*4 + c) matches the pair index k directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mat[i] <= '0;
      for (int i = 0; i < 4; i++)  pix[i] <= '0;
    end else if (wr_en && wr_ok) begin
      if (!wr_addr[4])
        mat[wr_addr[3:0]] <= wr_data;
      else if (wr_addr[3:2] == 2'b00)
        pix[wr_addr[1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Scoreboard bench for matrix_operand_sequencer: driver queues expected pairs and completion
// times, a negedge monitor checks every strobe and seq_done pulse against them.
module tb_matrix_operand_sequencer;

`ifdef SEQ_WAIT_MULT_DONE_EN
  localparam int DONE_LAT = 39;
`else
  localparam int DONE_LAT = 33;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          t;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        mult_done;
  logic [31:0] in1, in2;
  logic        ready, busy, seq_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_ready = 1'b0;

  pair_t sb_q[$];
  int    done_q[$];

  int exp_m[16] = '{1, 1, 2, 3, 5, 6, 7, 3, 1, 2, 3, 2, 4, 5, 3, 5};
  int exp_p[4]  = '{2, 5, 3, 1};

  matrix_operand_sequencer #(.DATA_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .mult_done(mult_done), .in1(in1), .in2(in2),
    .inputs_to_multiply_ready(ready), .busy(busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_run(input int t, input bit zero);
    pair_t e;
    for (int k = 0; k < 16; k++) begin
      e.a = zero ? 32'd0 : 32'(exp_m[k]);
      e.b = zero ? 32'd0 : 32'(exp_p[k % 4]);
      e.t = t + 2 + 2 * k;
      sb_q.push_back(e);
    end
    done_q.push_back(t + DONE_LAT);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic write_op(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic expect_drained(input string name);
    int budget = 100;
    while ((sb_q.size() != 0 || done_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(name, 32'(sb_q.size() + done_q.size()), 32'd0);
  endtask

  // Multiplier stand-in: reports done so that seq_done lands at the queued time.
  always @(negedge clk)
    mult_done = (done_q.size() != 0) && (cyc + 1 == done_q[0] - 1);

  always @(negedge clk) begin
    if (!reset) begin
      if (ready) begin
        chk("strobe_not_consecutive", 32'(prev_ready), 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          pair_t e;
          e = sb_q.pop_front();
          chk("in1", in1, e.a);
          chk("in2", in2, e.b);
          chk("strobe_cycle", 32'(cyc), 32'(e.t));
        end
      end
      if (seq_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_seq_done", 32'd1, 32'd0);
        end else begin
          int t;
          t = done_q.pop_front();
          chk("seq_done_cycle", 32'(cyc), 32'(t));
          chk("busy_low_at_done", 32'(busy), 32'd0);
        end
      end
    end
    prev_ready <= ready;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, t2, t3;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; mult_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in1", in1, 32'd0);
    chk("reset_in2", in2, 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_seq_done", 32'(seq_done), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) write_op(5'(i), 16'(exp_m[i]));
    for (int i = 0; i < 4; i++)  write_op(5'(16 + i), 16'(exp_p[i]));
    write_op(5'd20, 16'd99);

    // Basic run with a write and a start pulse landing mid-run.
    @(negedge clk);
    t0 = cyc + 1; start = 1'b1; push_run(t0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 1);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_cyc(t0 + 4);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'd99;
    @(negedge clk);
    wr_en = 1'b0;
    wait_cyc(t0 + 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + DONE_LAT - 1);
    chk("busy_before_done", 32'(busy), 32'd1);
    chk("no_early_done", 32'(seq_done), 32'd0);
    expect_drained("basic_run_drained");

    // start held high: back-to-back runs, first operands unaffected by ignored writes.
    @(negedge clk);
    t1 = cyc + 1; start = 1'b1;
    push_run(t1, 1'b0);
    push_run(t1 + DONE_LAT + 1, 1'b0);
    wait_cyc(t1 + DONE_LAT + 2);
    start = 1'b0;
    expect_drained("held_start_drained");

    // Reset mid-run abandons the sequence after pairs 0..3.
    @(negedge clk);
    t2 = cyc + 1; start = 1'b1;
    for (int k = 0; k < 4; k++) sb_q.push_back('{32'(exp_m[k]), 32'(exp_p[k]), t2 + 2 + 2 * k});
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t2 + 9);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_ready", 32'(ready), 32'd0);
    chk("midreset_in1", in1, 32'd0);
    chk("midreset_in2", in2, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midreset_drained", 32'(sb_q.size() + done_q.size()), 32'd0);

    // Operands were cleared by reset: a new run issues zeros.
    @(negedge clk);
    t3 = cyc + 1; start = 1'b1; push_run(t3, 1'b1);
    @(negedge clk);
    start = 1'b0;
    expect_drained("zero_run_drained");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
